// File: rtl/cache_way_sel_pkg.sv
// Shared types and helpers for the cache way selector.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents:
//   state_t - controller state encoding (IDLE, EVICT, FILL, RESP)
//   clog2   - constant ceiling-log2 used to size way-index fields
package cache_way_sel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVICT = 2'd1,
    FILL  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/way_priority_encoder.sv
// Lowest-index-wins priority encoder over a per-way bit vector.
// Latency: combinational.
// Backpressure: n/a.
//
// Ports:
//   vec - per-way request bits
//   idx - index of the lowest set bit (0 when vec is all zero)
//   any - 1 when at least one bit of vec is set
module way_priority_encoder
  import cache_way_sel_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int IDX_W = clog2(WAYS)
) (
  input  logic [WAYS-1:0]  vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scanning from the top down lets the lowest set bit overwrite last.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_way_selector.sv
// Hit/victim way selection with writeback and fill sequencing; drives LRU update strobe.
// Latency: hit responds 1 cycle after request; miss responds 1 cycle after fill handshake.
// Backpressure: one transaction in flight; req_ready low outside IDLE; each phase holds until its ready.
//
// Ports:
//   clock, reset                 - clock; asynchronous active-low reset
//   req_valid/req_ready          - lookup handshake; hit/way_valid/way_dirty/lru sampled on it
//   access, access_valid         - one-cycle most-recently-used update to the LRU tracker
//   wb_valid/wb_ready, wb_way    - victim writeback handshake
//   fill_valid/fill_ready, fill_way - line fill handshake
//   resp_valid/resp_ready, resp_way, resp_hit - result handshake
//
// Build option: CACHE_WAY_SEL_INVALID_FIRST_EN - on a miss, prefer the lowest
// invalid way over the LRU way (such a victim never needs a writeback).
module cache_way_selector
  import cache_way_sel_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int IDX_W = clog2(WAYS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WAYS-1:0]  hit,
  input  logic [WAYS-1:0]  way_valid,
  input  logic [WAYS-1:0]  way_dirty,
  input  logic [WAYS-1:0]  lru,
  output logic [IDX_W-1:0] access,
  output logic             access_valid,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [IDX_W-1:0] wb_way,
  output logic             fill_valid,
  input  logic             fill_ready,
  output logic [IDX_W-1:0] fill_way,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [IDX_W-1:0] resp_way,
  output logic             resp_hit
);

  state_t           state_q;
  state_t           state_d;

  logic [IDX_W-1:0] hit_idx;
  logic             hit_any;
  logic [IDX_W-1:0] lru_idx;
  logic             lru_any;
  logic [IDX_W-1:0] victim_lru;
  logic [IDX_W-1:0] victim;
  logic             victim_dirty;
  logic [IDX_W-1:0] sel_way;
  logic             req_fire;
  logic             access_fire;

  way_priority_encoder #(.WAYS(WAYS), .IDX_W(IDX_W)) u_hit_enc (
    .vec (hit),
    .idx (hit_idx),
    .any (hit_any)
  );

  way_priority_encoder #(.WAYS(WAYS), .IDX_W(IDX_W)) u_lru_enc (
    .vec (lru),
    .idx (lru_idx),
    .any (lru_any)
  );

  // A tracker that reports no LRU way falls back to way 0.
  assign victim_lru = lru_any ? lru_idx : '0;

`ifdef CACHE_WAY_SEL_INVALID_FIRST_EN
  logic [IDX_W-1:0] inv_idx;
  logic             inv_any;

  way_priority_encoder #(.WAYS(WAYS), .IDX_W(IDX_W)) u_inv_enc (
    .vec (~way_valid),
    .idx (inv_idx),
    .any (inv_any)
  );

  assign victim = inv_any ? inv_idx : victim_lru;
`else
  assign victim = victim_lru;
`endif

  // Only a line that is both valid and dirty has data worth writing back.
  assign victim_dirty = way_valid[victim] & way_dirty[victim];
  assign sel_way      = hit_any ? hit_idx : victim;

  assign req_fire     = (state_q == IDLE) && req_valid;
  // The way becomes MRU on a hit at request time, on a miss when the fill lands.
  assign access_fire  = (req_fire && hit_any) || ((state_q == FILL) && fill_ready);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (hit_any)           state_d = RESP;
          else if (victim_dirty) state_d = EVICT;
          else                   state_d = FILL;
        end
      end
      EVICT:   if (wb_ready)   state_d = FILL;
      FILL:    if (fill_ready) state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every output is a flop; strobes are decoded from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_ready    <= 1'b1;
      access_valid <= 1'b0;
      wb_valid     <= 1'b0;
      fill_valid   <= 1'b0;
      resp_valid   <= 1'b0;
      resp_hit     <= 1'b0;
      access       <= '0;
      wb_way       <= '0;
      fill_way     <= '0;
      resp_way     <= '0;
    end else begin
      req_ready    <= (state_d == IDLE);
      wb_valid     <= (state_d == EVICT);
      fill_valid   <= (state_d == FILL);
      resp_valid   <= (state_d == RESP);
      access_valid <= access_fire;
      // The selected way is frozen at the request handshake; later input
      // changes cannot disturb an in-flight transaction.
      if (req_fire) begin
        access   <= sel_way;
        wb_way   <= sel_way;
        fill_way <= sel_way;
        resp_way <= sel_way;
        resp_hit <= hit_any;
      end
    end
  end

endmodule

// File: tb/tb_cache_way_selector.sv
// Self-checking bench for cache_way_selector (WAYS=4).
// Latency: n/a.
// Backpressure: bench drives ready signals with programmable per-phase stalls.
module tb_cache_way_selector;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] hit = '0;
  logic [3:0] way_valid = '0;
  logic [3:0] way_dirty = '0;
  logic [3:0] lru = '0;
  logic [1:0] access;
  logic       access_valid;
  logic       wb_valid;
  logic       wb_ready = 1'b0;
  logic [1:0] wb_way;
  logic       fill_valid;
  logic       fill_ready = 1'b0;
  logic [1:0] fill_way;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic [1:0] resp_way;
  logic       resp_hit;

  cache_way_selector #(.WAYS(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .hit          (hit),
    .way_valid    (way_valid),
    .way_dirty    (way_dirty),
    .lru          (lru),
    .access       (access),
    .access_valid (access_valid),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_way       (wb_way),
    .fill_valid   (fill_valid),
    .fill_ready   (fill_ready),
    .fill_way     (fill_way),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_way     (resp_way),
    .resp_hit     (resp_hit)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  function automatic int first_set(input logic [3:0] x);
    for (int i = 0; i < 4; i++) if (x[i]) return i;
    return 0;
  endfunction

  function automatic void model_txn(input logic [3:0] h, input logic [3:0] v,
                                    input logic [3:0] d, input logic [3:0] l,
                                    output int way, output bit is_hit, output bit evict);
    way = 0; is_hit = 1'b0; evict = 1'b0;
    if (h != 4'b0) begin
      is_hit = 1'b1;
      way    = first_set(h);
    end else begin
      way = first_set(l);
`ifdef CACHE_WAY_SEL_INVALID_FIRST_EN
      if (v != 4'hF) way = first_set(~v);
`endif
      evict = v[way] && d[way];
    end
  endfunction

  // model state for the transaction in flight
  bit busy = 1'b0, exp_hit = 1'b0, exp_evict = 1'b0, wb_done = 1'b0, fill_done = 1'b0;
  int exp_way = 0, acc_cnt = 0, last_acc_cnt = 0;
  // observations used by the directed literal checks
  int obs_fill_way = -1, obs_access = -1, obs_resp_way = -1, obs_resp_hit = -1;
  bit obs_wb_seen = 1'b0;
  // outputs sampled at the negedge before each rising edge
  bit rr_s = 1'b0, wbv_s = 1'b0, flv_s = 1'b0, rsv_s = 1'b0;

  // Handshake tracker: advances the model at each rising edge.
  always @(posedge clock) begin
    if (reset) begin
      if (req_valid && rr_s) begin
        model_txn(hit, way_valid, way_dirty, lru, exp_way, exp_hit, exp_evict);
        busy = 1'b1; wb_done = 1'b0; fill_done = 1'b0; acc_cnt = 0;
        obs_wb_seen = 1'b0; obs_fill_way = -1; obs_access = -1;
        obs_resp_way = -1; obs_resp_hit = -1;
      end else if (busy) begin
        if (wbv_s && wb_ready)   wb_done = 1'b1;
        if (flv_s && fill_ready) fill_done = 1'b1;
        if (rsv_s && resp_ready) begin
          chk("access_once_per_txn", acc_cnt, 1);
          last_acc_cnt = acc_cnt;
          busy = 1'b0;
        end
      end
    end
  end

  // Compare process: every cycle, check outputs against the model.
  always @(negedge clock) begin
    rr_s = req_ready; wbv_s = wb_valid; flv_s = fill_valid; rsv_s = resp_valid;
    if (!reset) begin
      busy = 1'b0;
      chk("rst_req_ready", int'(req_ready), 1);
      chk("rst_strobes", int'({access_valid, wb_valid, fill_valid, resp_valid}), 0);
    end else if (!busy) begin
      chk("idle_req_ready", int'(req_ready), 1);
      chk("idle_strobes", int'({access_valid, wb_valid, fill_valid, resp_valid}), 0);
    end else begin
      chk("busy_req_ready", int'(req_ready), 0);
      if (access_valid) begin
        acc_cnt++;
        obs_access = int'(access);
        chk("access_way", int'(access), exp_way);
        chk("access_phase", int'(exp_hit || fill_done), 1);
      end
      if (wb_valid) begin
        obs_wb_seen = 1'b1;
        chk("wb_way", int'(wb_way), exp_way);
        chk("wb_phase", int'(exp_evict && !wb_done), 1);
      end
      if (fill_valid) begin
        obs_fill_way = int'(fill_way);
        chk("fill_way", int'(fill_way), exp_way);
        chk("fill_phase", int'(!exp_hit && (!exp_evict || wb_done) && !fill_done), 1);
      end
      if (resp_valid) begin
        obs_resp_way = int'(resp_way);
        obs_resp_hit = int'(resp_hit);
        chk("resp_way", int'(resp_way), exp_way);
        chk("resp_hit", int'(resp_hit), int'(exp_hit));
        chk("resp_phase", int'(exp_hit || fill_done), 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Returns at #1 after the handshake edge; inputs are scrambled afterwards
  // so a late capture would be visible.
  task automatic do_req(input logic [3:0] h, input logic [3:0] v,
                        input logic [3:0] d, input logic [3:0] l);
    @(posedge clock); #1;
    hit = h; way_valid = v; way_dirty = d; lru = l; req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (req_ready) begin
        @(posedge clock); #1;
        req_valid = 1'b0; hit = ~h; way_valid = ~v; way_dirty = 4'hF; lru = 4'b0100;
        return;
      end
    end
    chk("req_timeout", 0, 1);
    req_valid = 1'b0;
  endtask

  task automatic finish_txn(input int wb_delay, input int fill_delay,
                            input int resp_delay, input bit early_fill);
    int wc, fc, rc;
    bit done;
    wc = 0; fc = 0; rc = 0; done = 1'b0;
    fill_ready = early_fill;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      if (!busy) done = 1'b1;
      else begin
        wb_ready   = wb_valid && (wc >= wb_delay);
        if (wb_valid) wc++;
        fill_ready = early_fill || (fill_valid && (fc >= fill_delay));
        if (fill_valid) fc++;
        resp_ready = resp_valid && (rc >= resp_delay);
        if (resp_valid) rc++;
      end
    end
    if (!done) chk("txn_timeout", 0, 1);
    wb_ready = 1'b0; fill_ready = 1'b0; resp_ready = 1'b0;
  endtask

  int exp_v;

  initial begin
    #2 reset = 1'b0;
    #1;
    chk("reset_req_ready", int'(req_ready), 1);
    chk("reset_access_valid", int'(access_valid), 0);
    chk("reset_wb_valid", int'(wb_valid), 0);
    chk("reset_fill_valid", int'(fill_valid), 0);
    chk("reset_resp_valid", int'(resp_valid), 0);
    chk("reset_resp_hit", int'(resp_hit), 0);
    chk("reset_ways", int'({access, wb_way, fill_way, resp_way}), 0);
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;

    // Hit on way 2: access and response at N+1, no writeback/fill.
    do_req(4'b0100, 4'b1111, 4'b0000, 4'b0001);
    @(negedge clock);
    chk("hit_n1_access_valid", int'(access_valid), 1);
    chk("hit_n1_access", int'(access), 2);
    chk("hit_n1_resp_valid", int'(resp_valid), 1);
    chk("hit_n1_resp_way", int'(resp_way), 2);
    chk("hit_n1_resp_hit", int'(resp_hit), 1);
    chk("hit_n1_no_wb_fill", int'({wb_valid, fill_valid}), 0);
    finish_txn(0, 0, 0, 1'b0);

    // Dirty miss on way 3 with writeback stalled 5 cycles.
    do_req(4'b0000, 4'b1111, 4'b1000, 4'b1000);
    @(negedge clock);
    chk("dirty_n1_wb_valid", int'(wb_valid), 1);
    chk("dirty_n1_wb_way", int'(wb_way), 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("dirty_stall_wb_valid", int'(wb_valid), 1);
      chk("dirty_stall_fill_low", int'(fill_valid), 0);
    end
    finish_txn(0, 1, 0, 1'b0);
    chk("dirty_fill_way", obs_fill_way, 3);
    chk("dirty_access", obs_access, 3);
    chk("dirty_resp_hit", obs_resp_hit, 0);

    // Clean miss on way 1.
    do_req(4'b0000, 4'b1111, 4'b0000, 4'b0010);
    finish_txn(0, 2, 0, 1'b0);
    chk("clean_no_wb", int'(obs_wb_seen), 0);
    chk("clean_fill_way", obs_fill_way, 1);
    chk("clean_resp_way", obs_resp_way, 1);

    // Invalid way present: build option decides the victim.
`ifdef CACHE_WAY_SEL_INVALID_FIRST_EN
    exp_v = 2;
`else
    exp_v = 0;
`endif
    do_req(4'b0000, 4'b1011, 4'b0000, 4'b0001);
    finish_txn(0, 0, 0, 1'b0);
    chk("invfirst_fill_way", obs_fill_way, exp_v);
    chk("invfirst_no_wb", int'(obs_wb_seen), 0);

    // Response stalled 3 cycles on a hit to way 3.
    do_req(4'b1000, 4'b1111, 4'b0000, 4'b0001);
    finish_txn(0, 0, 3, 1'b0);
    chk("stall_access_pulses", last_acc_cnt, 1);
    chk("stall_resp_way", obs_resp_way, 3);

    // Boundary patterns: multi-hot hit, all-zero lru, multi-hot lru with
    // early fill_ready, invalid-but-dirty victim.
    do_req(4'b1010, 4'b1111, 4'b1111, 4'b0001);
    finish_txn(0, 0, 0, 1'b0);
    chk("multihit_resp_way", obs_resp_way, 1);
    do_req(4'b0000, 4'b1111, 4'b0001, 4'b0000);
    finish_txn(1, 0, 0, 1'b0);
    chk("lru_zero_wb", int'(obs_wb_seen), 1);
    chk("lru_zero_fill_way", obs_fill_way, 0);
    do_req(4'b0000, 4'b1111, 4'b0100, 4'b1100);
    finish_txn(2, 0, 1, 1'b1);
    chk("lru_multi_fill_way", obs_fill_way, 2);
    chk("lru_multi_wb", int'(obs_wb_seen), 1);
    do_req(4'b0000, 4'b1101, 4'b0010, 4'b0010);
    finish_txn(0, 0, 0, 1'b0);
    chk("invalid_dirty_no_wb", int'(obs_wb_seen), 0);
    chk("invalid_dirty_way", obs_fill_way, 1);

    // Reset while in FILL aborts immediately.
    do_req(4'b0000, 4'b1111, 4'b0000, 4'b0100);
    @(negedge clock);
    chk("abort_fill_valid_before", int'(fill_valid), 1);
    chk("abort_fill_way_before", int'(fill_way), 2);
    #2 reset = 1'b0;
    #1;
    chk("abort_fill_valid", int'(fill_valid), 0);
    chk("abort_req_ready", int'(req_ready), 1);
    chk("abort_access_valid", int'(access_valid), 0);
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    do_req(4'b1000, 4'b1111, 4'b0000, 4'b0001);
    finish_txn(0, 0, 0, 1'b0);
    chk("post_abort_resp_way", obs_resp_way, 3);
    chk("post_abort_resp_hit", obs_resp_hit, 1);
    repeat (3) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cache_way_selector.md
# cache_way_selector

Replacement controller that drives the access side of the cache's LRU tracker and consumes its one-hot `lru` vector. Per lookup it takes the tag-compare hit vector and per-way valid/dirty bits. On a hit it reports the hit way. On a miss it picks a victim, runs an optional writeback handshake and then a fill handshake, and reports the way. It issues the `access`/`access_valid` update to the LRU tracker at the point the way becomes most recently used. It sits in the cache controller between the tag arrays and the memory-side interface.

## Interface
- `WAYS`, 4: associativity; power of two, ≥2.
- `IDX_W`, clog2(WAYS): way-index width.

Ports:
- `clock`  in  1  — single clock; all logic on its rising edge.
- `reset`  in  1  — asynchronous, active-low; asserting (0) resets immediately, deassertion is synchronous to `clock`.
- `req_valid`  in  1  — lookup request.
- `req_ready`  out  1  — request accepted when both are high.
- `hit`  in  WAYS  — tag-match vector; sampled at request handshake.
- `way_valid`  in  WAYS  — line valid bits; sampled at request handshake.
- `way_dirty`  in  WAYS  — line dirty bits; sampled at request handshake.
- `lru`  in  WAYS  — one-hot least-recently-used way from the LRU tracker; sampled at request handshake.
- `access`  out  IDX_W  — way to mark most recently used.
- `access_valid`  out  1  — one-cycle update strobe to the LRU tracker.
- `wb_valid` / `wb_ready`  out / in  1 each  — victim writeback handshake.
- `wb_way`  out  IDX_W  — way to write back.
- `fill_valid` / `fill_ready`  out / in  1 each  — line fill handshake.
- `fill_way`  out  IDX_W  — way being filled.
- `resp_valid` / `resp_ready`  out / in  1 each  — result handshake.
- `resp_way`  out  IDX_W  — selected way.
- `resp_hit`  out  1  — 1 = hit, 0 = miss serviced.

## Operation
- States: IDLE, EVICT, FILL, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, register `hit`, `way_valid`, `way_dirty` and `lru`, and select the way.
- **Hit** (`hit` non-zero)
  - Way = lowest set bit of `hit`; a multi-hot `hit` is a tag-array error, lowest index wins.
  - Pulse `access_valid` with `access`=way, set `resp_hit`=1, go to RESP.
- **Miss** (`hit`=0)
  - Victim = encode(`lru`); all-zero `lru` selects way 0, multi-hot selects lowest index.
  - If the victim is valid and dirty, go to EVICT; otherwise go to FILL.
- **EVICT**
  - Hold `wb_valid`=1 and `wb_way`=victim until `wb_ready`; then go to FILL.
- **FILL**
  - Hold `fill_valid`=1 and `fill_way`=victim until `fill_ready`.
  - On that handshake, pulse `access_valid` with `access`=victim, set `resp_hit`=0, go to RESP.
- **RESP**
  - Hold `resp_valid`=1 with `resp_way`/`resp_hit` stable until `resp_ready`; then go to IDLE.
- Only one transaction is in flight. `req_ready`=0 in every state except IDLE.
- Changes on `hit`/`way_valid`/`way_dirty`/`lru` after the handshake are ignored.
- `access_valid` fires exactly once per transaction.

## Timing
- All outputs are registered.
- Reset values: `req_ready`=1 (IDLE); `access_valid`, `wb_valid`, `fill_valid`, `resp_valid`, `resp_hit`=0; `access`, `wb_way`, `fill_way`, `resp_way`=0.
- Hit: handshake at cycle N; `access_valid` and `resp_valid` both high at N+1. Earliest next request at N+2 when `resp_ready`=1 at N+1.
- Clean miss: `fill_valid` at N+1. `fill_ready` at cycle F gives `access_valid` and `resp_valid` at F+1.
- Dirty miss: `wb_valid` at N+1. `wb_ready` at W gives `fill_valid` at W+1.
- Valid/ready signals at 1 in the same cycle complete the handshake in that cycle. A `ready` asserted before its `valid` has no effect.
- `access_valid` is high for exactly one cycle, including when `resp_ready` stalls.
- Reset mid-transaction aborts it and returns to IDLE with all strobes 0. No `access_valid` is emitted for the aborted transaction.

## Configuration
- `CACHE_WAY_SEL_INVALID_FIRST_EN` defined: on a miss with any invalid way captured, the victim is the lowest-index invalid way and `lru` is ignored. Such a victim never goes through EVICT.
- Undefined: the victim is always taken from `lru`.

## Structure
- Shared package `cache_way_sel_pkg`: state enum (IDLE/EVICT/FILL/RESP) and a `clog2` constant function.
- One sub-module, `way_priority_encoder` (WAYS in → IDX_W index + `any` flag, lowest index wins). It is instantiated for `hit`, `lru` and, when enabled, for ~`way_valid`.

## Test plan
- WAYS=4, `hit`=0100 → `resp_way`=2, `resp_hit`=1, one `access_valid` pulse with `access`=2 at N+1; no `wb_valid` or `fill_valid`.
- `hit`=0, `lru`=1000, `way_valid`=1111, `way_dirty`=1000 → `wb_way`=3. Hold `wb_ready`=0 for 5 cycles → `wb_valid` stays high and `fill_valid` stays low. Then `fill_way`=3, `access`=3, `resp_hit`=0.
- `hit`=0, `lru`=0010, `way_dirty`=0000 → no `wb_valid`, `fill_way`=1, `resp_way`=1.
- With `CACHE_WAY_SEL_INVALID_FIRST_EN`: `way_valid`=1011, `lru`=0001 → victim 2. Without the macro → victim 0.
- `resp_ready`=0 for 3 cycles → `resp_valid` and `resp_way` stable, `access_valid` high for only 1 cycle, `req_ready`=0 throughout.
- `reset`=0 asserted while in FILL → `fill_valid`=0 immediately, `req_ready`=1; a new hit request afterwards completes normally.
